// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and defaults for the push-button front end.
//   deb_state_t         : debouncer FSM state (LOW, RISE, HIGH, FALL)
//   DEF_SYNC_STAGES     : default synchroniser depth
//   DEF_DEBOUNCE_CYCLES : default number of qualifying samples
//   cnt_width()         : counter width helper, never narrower than 1 bit
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,  // output 0, input agrees
    RISE = 2'd1,  // output 0, qualifying a 1
    HIGH = 2'd2,  // output 1, input agrees
    FALL = 2'd3   // output 1, qualifying a 0
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// SYNC_STAGES-deep flip-flop synchroniser for a single asynchronous input.
// Reusable for any slow async level input in the clk domain.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset, clears every stage to 0
//   i_d : asynchronous input level
//   o_q : synchronised level (last stage of the chain)
// ---------------------------------------------------------------------------
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronises a raw, bouncy push-button level into the clk domain and
// filters contact bounce: the output only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it. Any reversal during
// qualification restarts the count.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-low reset
//   press_i     : raw button level, asynchronous, may bounce
//   syncpress_o : debounced level (registered), active-high
//   bouncing_o  : high while a candidate transition is being qualified
// Optional build macro:
//   BUTTON_DEBOUNCER_ACTIVE_LOW_IN_EN : invert press_i ahead of the
//   synchroniser for pull-up buttons (pressed reads 0). The chain still
//   resets to 0, which then means "not pressed".
// ---------------------------------------------------------------------------
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic press_i,
  output logic syncpress_o,
  output logic bouncing_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_press_in;
  logic             w_s;
  deb_state_t       r_state;
  deb_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_syncpress;
  logic             r_bouncing;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_IN_EN
  assign w_press_in = ~press_i;
`else
  assign w_press_in = press_i;
`endif

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (w_press_in),
    .o_q (w_s)
  );

  // Next-state logic. The counter holds the number of consecutive
  // disagreeing samples seen so far; it is only non-zero in RISE/FALL and
  // never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      LOW: begin
        if (w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = HIGH;
            w_cnt_next   = '0;
          end else begin
            w_state_next = RISE;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      RISE: begin
        if (!w_s) begin
          w_state_next = LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = LOW;
            w_cnt_next   = '0;
          end else begin
            w_state_next = FALL;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      FALL: begin
        if (w_s) begin
          w_state_next = HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter and outputs. Outputs are decoded from the next state so
  // they are plain flops that always agree with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= LOW;
      r_cnt       <= '0;
      r_syncpress <= 1'b0;
      r_bouncing  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_syncpress <= (w_state_next == HIGH) || (w_state_next == FALL);
      r_bouncing  <= (w_state_next == RISE) || (w_state_next == FALL);
    end
  end

  assign syncpress_o = r_syncpress;
  assign bouncing_o  = r_bouncing;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
// Two instances share clk/rst/press: one with default parameters and one
// with DEBOUNCE_CYCLES=1. Stimulus is expressed as the "pressed" level p;
// the pin value is p inverted when the active-low build macro is defined.
// Reference model: a sample delay line of SYNC_STAGES edges feeding a
// history of synchronised samples; the output flips when the most recent
// DEBOUNCE_CYCLES samples all disagree with it, and the block reports
// bouncing whenever the latest sample disagrees with the output.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB0 = 4;
  localparam int DEB1 = 1;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_IN_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p   = 1'b0;
  logic press;
  logic sp0, bo0, sp1, bo1;

  int n_checks = 0;
  int n_fail   = 0;

  assign press = p ^ INV;

  always #5 clk = ~clk;

  button_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB0)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .press_i     (press),
    .syncpress_o (sp0),
    .bouncing_o  (bo0)
  );

  button_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .press_i     (press),
    .syncpress_o (sp1),
    .bouncing_o  (bo1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        pipe_m [SYNC];
  logic        out_m  [2];
  logic        bnc_m  [2];
  logic [15:0] hist_m [2];
  int          nval_m [2];
  int          deb_m  [2];
  logic        s_m;
  bit          model_ok = 1'b0;
  bit          deb1_bnc_seen = 1'b0;

  function automatic bit qualifies(input logic [15:0] h, input int n,
                                   input int deb, input logic out);
    if (n < deb) return 1'b0;
    for (int j = 0; j < deb; j++) begin
      if (h[j] == out) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    deb_m[0] = DEB0;
    deb_m[1] = DEB1;
    forever begin
      @(posedge clk);
      if (!rst) begin
        for (int j = 0; j < SYNC; j++) pipe_m[j] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          out_m[i]  = 1'b0;
          bnc_m[i]  = 1'b0;
          hist_m[i] = '0;
          nval_m[i] = 0;
        end
        model_ok = 1'b1;
      end else begin
        s_m = pipe_m[SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) pipe_m[j] = pipe_m[j-1];
        pipe_m[0] = p;
        for (int i = 0; i < 2; i++) begin
          hist_m[i] = {hist_m[i][14:0], s_m};
          if (nval_m[i] < 16) nval_m[i]++;
          if (qualifies(hist_m[i], nval_m[i], deb_m[i], out_m[i]))
            out_m[i] = ~out_m[i];
          bnc_m[i] = (s_m != out_m[i]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("model_sync0", sp0, out_m[0]);
        chk("model_bounce0", bo0, bnc_m[0]);
        chk("model_sync1", sp1, out_m[1]);
        chk("model_bounce1", bo1, bnc_m[1]);
        if (bo1 !== 1'b0) deb1_bnc_seen = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus + literal expectations ----------------
  bit bpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int n_changes;
  logic prev_sp;

  initial begin
    // Reset held with the button pressed: outputs stay quiet.
    p   = 1'b1;
    rst = 1'b0;
    repeat (2) begin
      tick();
      chk("rst_sync", sp0, 1'b0);
      chk("rst_bounce", bo0, 1'b0);
    end
    $display("txn reset_hold: sync=%b bounce=%b", sp0, bo0);

    // Release reset: output rises 5 edges after the first non-reset edge.
    rst = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      chk("rel_sync", sp0, logic'(e == 5));
      chk("rel_bounce", bo0, logic'(e >= 2 && e <= 4));
    end
    $display("txn reset_release: sync=%b", sp0);

    // Clean release.
    p = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      chk("clean_rel_sync", sp0, logic'(e < 5));
      chk("clean_rel_bounce", bo0, logic'(e >= 2 && e <= 4));
    end
    $display("txn clean_release: sync=%b", sp0);

    // Bouncy press: 1,0,1,1,0,1 then stable 1.
    n_changes = 0;
    prev_sp   = sp0;
    for (int e = 0; e <= 11; e++) begin
      p = (e < 6) ? bpat[e] : 1'b1;
      tick();
      chk("bounce_sync", sp0, logic'(e >= 10));
      if (sp0 !== prev_sp) n_changes++;
      prev_sp = sp0;
    end
    chk("bounce_one_change", logic'(n_changes == 1), 1'b1);
    $display("txn bounce_press: sync=%b changes=%0d", sp0, n_changes);

    p = 1'b0;
    repeat (8) tick();

    // Single-cycle glitch from LOW.
    for (int e = 0; e <= 7; e++) begin
      p = (e == 0) ? 1'b1 : 1'b0;
      tick();
      chk("glitch_sync", sp0, 1'b0);
      chk("glitch_bounce", bo0, logic'(e == 2));
      chk("deb1_follow", sp1, logic'(e == 2));
    end
    $display("txn glitch: sync=%b deb1_sync=%b", sp0, sp1);

    // Reset in the middle of a qualification.
    p = 1'b1;
    for (int e = 0; e <= 3; e++) tick();
    chk("midq_bouncing", bo0, 1'b1);
    rst = 1'b0;
    tick();
    chk("midq_rst_sync", sp0, 1'b0);
    chk("midq_rst_bounce", bo0, 1'b0);
    rst = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      chk("midq_after_sync", sp0, logic'(e == 5));
    end
    $display("txn reset_mid_qualify: sync=%b", sp0);

    p = 1'b0;
    repeat (8) tick();

    // Randomised holds with occasional resets, checked by the model.
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b1;
      end
      p = logic'($urandom_range(0, 1));
      repeat ($urandom_range(1, 7)) tick();
      $display("txn random %0d: p=%b sync0=%b sync1=%b", it, p, sp0, sp1);
    end

    chk("deb1_never_bounced", logic'(deb1_bnc_seen), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front end of the push-button input path. Takes the raw, asynchronous, bouncy button pin and synchronises it into the clk domain through a flip-flop chain.
- Filters contact bounce with a consecutive-sample counter FSM.
- Drives the clean, debounced level syncpress_o that feeds the single-pulser stage directly downstream.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range ≥2.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples that must differ from the current output before the output changes; legal range ≥1.
- CNT_W, max(1,$clog2(DEBOUNCE_CYCLES)), counter width; localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 sampled at posedge clk resets the block).
- press_i  input  1  raw button level, asynchronous to clk, may bounce.
- syncpress_o  output  1  synchronised, debounced button level for the single pulser.
- bouncing_o  output  1  high while a candidate transition is being qualified (state RISE or FALL).

Behaviour:
- Reset (rst==0 at a posedge clk):
  - Sync chain cleared to 0, counter to 0, state to LOW.
  - syncpress_o=0, bouncing_o=0.
  - Reset asserted mid-qualification aborts it with no output change.
  - Reset dominates all other events in that cycle.
- Synchroniser:
  - s = last stage of an SYNC_STAGES-deep shift register clocked from press_i.
  - No combinational path from press_i to any output.
- FSM states: LOW (out 0), RISE (out 0, qualifying 1), HIGH (out 1), FALL (out 1, qualifying 0).
- Transitions:
  - LOW: s==1 → RISE, cnt=1. If DEBOUNCE_CYCLES==1 → HIGH directly.
  - RISE:
    - s==0 → LOW, cnt=0.
    - s==1 and cnt==DEBOUNCE_CYCLES-1 → HIGH, cnt=0.
    - Otherwise cnt+1.
  - HIGH, FALL: mirror images of LOW and RISE with the polarity swapped.
- Outputs:
  - syncpress_o is registered: 1 in HIGH and FALL, 0 in LOW and RISE.
  - bouncing_o is 1 in RISE and FALL only.
- Latency: a clean press_i edge that is stable before posedge k moves syncpress_o at posedge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (5 edges with defaults).
- Glitch rejection: any run of fewer than DEBOUNCE_CYCLES equal synchronised samples is discarded; the counter restarts on every reversal.
- Counter never wraps: its maximum held value is DEBOUNCE_CYCLES-1.
- Output change rate: at most one output change per DEBOUNCE_CYCLES cycles.
- press_i held constant indefinitely: the state stays in LOW or HIGH and the counter stays at 0.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_ACTIVE_LOW_IN_EN.
- Defined: press_i is inverted before the first synchroniser flop, for pull-up buttons where pressed reads 0.
  - Sync chain still resets to 0 (the "not pressed" level), so no spurious press follows reset.
- Undefined: press_i is used as-is (pressed = 1).
- syncpress_o is active-high in both builds.

Decomposition:
- Shared package debounce_pkg:
  - State enum typedef (LOW, RISE, HIGH, FALL; 2-bit encoding).
  - Default constants DEF_SYNC_STAGES=2 and DEF_DEBOUNCE_CYCLES=4.
- One natural sub-module: sync_chain, a parameterised SYNC_STAGES-deep synchroniser with the same clk/rst, reusable for other async inputs.
- Counter and FSM stay in the top module.

Test Plan:
1. Reset: hold rst=0 for 2 edges while press_i=1 → syncpress_o=0 and bouncing_o=0 throughout; release rst → syncpress_o rises exactly 5 edges later.
2. Clean press: press_i 0→1 before edge k → bouncing_o high from edge k+2 to k+4, syncpress_o=1 at edge k+5; release mirrors this, syncpress_o=0 at edge k'+5.
3. Bounce: press_i pattern 1,0,1,1,0,1 then stable 1, one sample per cycle → syncpress_o changes once only, 4 edges after the synchronised stable run begins; no pulse during the bounce.
4. Glitch: a single-cycle 1 on press_i with output LOW → bouncing_o pulses for 1 cycle, syncpress_o stays 0.
5. Reset mid-qualification: drive rst=0 while in RISE with cnt=2 → next edge gives state LOW, cnt=0, syncpress_o=0.
6. Parameter and macro sweep:
   - DEBOUNCE_CYCLES=1 → output follows s with 1 edge of delay and bouncing_o is never asserted.
   - BUTTON_DEBOUNCER_ACTIVE_LOW_IN_EN defined, press_i 1→0 → syncpress_o=1 after 5 edges.
